// File: rtl/uart_mem_loader_pkg.sv
// uart_mem_loader_pkg
//   Shared types and constants for the UART boot/debug memory loader.
//   Imported by uart_mem_loader and uart_mem_byte_packer.
package uart_mem_loader_pkg;

    localparam int          MEM_DEPTH     = 8192;   // words in the target memory
    localparam int          LEN_W         = 14;     // frame length field width (words)
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;  // default frame start marker

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_LO,
        S_ADDR_HI,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CSUM
    } state_t;

endpackage

// File: rtl/uart_mem_byte_packer.sv
// uart_mem_byte_packer
//   Collects four bytes little-endian into a 32-bit word (first byte lands in
//   [7:0]). A byte counter tracks position; full is set once the 4th byte is in.
// Ports
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   clr      in   synchronous clear of counter, word and full flag
//   byte_en  in   shift byte_in into the word this cycle
//   byte_in  in   8-bit data byte
//   word     out  packed 32-bit word
//   full     out  four bytes collected since the last clear
//   last     out  next accepted byte completes the word
module uart_mem_byte_packer
    import uart_mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        full,
    output logic        last
);

    logic [1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt  <= 2'd0;
            word <= 32'd0;
            full <= 1'b0;
        end else if (byte_en) begin
            // shift right: after four bytes the first one sits in [7:0]
            word <= {byte_in, word[31:8]};
            cnt  <= cnt + 2'd1;
            full <= (cnt == 2'd3);
        end
    end

    assign last = (cnt == 2'd3);

endmodule

// File: rtl/uart_mem_loader.sv
// uart_mem_loader
//   Boot/debug loader in front of the 8192x32 single-port memory. Parses a UART
//   byte stream of frames: SYNC, addr[7:0], addr[12:8], len[7:0], len[13:8],
//   then 4*len data bytes, and writes each packed word through an s1-style port.
//   Optional feature macro: UART_MEM_LOADER_CSUM_EN -- a trailing XOR checksum
//   byte (over all bytes after sync) is checked before done is pulsed.
// Ports
//   clk, reset         clock, synchronous active-high reset
//   rx_data/valid/ready  byte stream in; byte consumed on rx_valid & rx_ready
//   mem_*              memory write port (address, byteenable, chipselect,
//                      write, writedata, clken)
//   busy               frame in progress
//   done / error       one-cycle pulses: frame completed / frame aborted
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int         ADDR_W         = 13,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [23:0]      TO_LAST = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MEM_DEPTH);

    state_t             state;
    logic [ADDR_W-1:0]  ptr;
    logic [LEN_W-1:0]   remaining;
    logic [7:0]         len_lo;
    logic [23:0]        timer;
    logic [7:0]         csum;

    logic               accept;
    logic               timed;
    logic               timeout_hit;
    logic [LEN_W-1:0]   len_full;
    logic               is_wr;

    logic [31:0]        pk_word;
    logic               pk_full;
    logic               pk_last;
    logic               pk_clr;

    assign accept      = rx_valid && rx_ready;
    assign timed       = (state != S_IDLE) && (state != S_WRITE);
    assign timeout_hit = timed && !accept && (timer == TO_LAST);
    assign len_full    = {rx_data[5:0], len_lo};

    // Packer is emptied after each write and whenever a frame is abandoned,
    // so a partial word never leaks into the next frame.
    assign pk_clr = (state == S_IDLE) || (state == S_WRITE) || timeout_hit;

    uart_mem_byte_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .clr     (pk_clr),
        .byte_en (accept && (state == S_DATA)),
        .byte_in (rx_data),
        .word    (pk_word),
        .full    (pk_full),
        .last    (pk_last)
    );

    // Memory port is driven straight from the registered state so the write
    // lands exactly in the WRITE cycle; bus is held quiet otherwise.
    assign is_wr          = (state == S_WRITE) && pk_full;
    assign mem_write      = is_wr;
    assign mem_chipselect = is_wr;
    assign mem_byteenable = is_wr ? 4'hF : 4'h0;
    assign mem_address    = is_wr ? ptr : '0;
    assign mem_writedata  = is_wr ? pk_word : 32'd0;
    assign mem_clken      = 1'b1;
    assign rx_ready       = (state != S_WRITE);
    assign busy           = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            remaining <= '0;
            len_lo    <= 8'd0;
            timer     <= 24'd0;
            csum      <= 8'd0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;

            if (!timed || accept) timer <= 24'd0;
            else                  timer <= timer + 24'd1;

            if (timeout_hit) begin
                error <= 1'b1;
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept && rx_data == SYNC_BYTE) begin
                            csum  <= 8'd0;
                            state <= S_ADDR_LO;
                        end
                    end
                    S_ADDR_LO: begin
                        if (accept) begin
                            ptr[7:0] <= rx_data;
                            csum     <= csum ^ rx_data;
                            state    <= S_ADDR_HI;
                        end
                    end
                    S_ADDR_HI: begin
                        if (accept) begin
                            ptr[ADDR_W-1:8] <= rx_data[ADDR_W-9:0];
                            csum            <= csum ^ rx_data;
                            state           <= S_LEN_LO;
                        end
                    end
                    S_LEN_LO: begin
                        if (accept) begin
                            len_lo <= rx_data;
                            csum   <= csum ^ rx_data;
                            state  <= S_LEN_HI;
                        end
                    end
                    S_LEN_HI: begin
                        if (accept) begin
                            remaining <= len_full;
                            csum      <= csum ^ rx_data;
                            if (len_full == '0) begin
`ifdef UART_MEM_LOADER_CSUM_EN
                                state <= S_CSUM;
`else
                                done  <= 1'b1;
                                state <= S_IDLE;
`endif
                            end else if (len_full > MAX_LEN) begin
                                error <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (accept) begin
                            csum <= csum ^ rx_data;
                            if (pk_last) state <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        ptr       <= ptr + 1'b1;  // natural wrap at the top of memory
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
`ifdef UART_MEM_LOADER_CSUM_EN
                            state <= S_CSUM;
`else
                            done  <= 1'b1;
                            state <= S_IDLE;
`endif
                        end else begin
                            state <= S_DATA;
                        end
                    end
`ifdef UART_MEM_LOADER_CSUM_EN
                    S_CSUM: begin
                        if (accept) begin
                            if (rx_data == csum) done  <= 1'b1;
                            else                 error <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader
//   Directed bench for uart_mem_loader. A negedge monitor logs every memory
//   write and counts done/error pulses; each test task snapshots those logs,
//   drives a frame and compares the deltas against hand-computed values.
//   Frames gain a trailing checksum byte when UART_MEM_LOADER_CSUM_EN is set.
module tb_uart_mem_loader;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    uart_mem_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    int vectors = 0;
    int miscompares = 0;

    // ---------------- monitor ----------------
    logic [12:0] wa[$];
    logic [31:0] wd[$];
    int n_done = 0, n_err = 0, rdy_bad = 0, both_bad = 0, be_bad = 0;

    always @(negedge clk) begin
        if (mem_write) begin
            wa.push_back(mem_address);
            wd.push_back(mem_writedata);
            if (mem_byteenable !== 4'hF || mem_chipselect !== 1'b1) be_bad++;
        end
        if (done)  n_done++;
        if (error) n_err++;
        if (done && error) both_bad++;
        if (!reset && (rx_ready === mem_write)) rdy_bad++;
    end

    int b_w, b_d, b_e;
    task automatic snap;
        b_w = wa.size(); b_d = n_done; b_e = n_err;
    endtask

    // ---------------- frame builder ----------------
    logic [7:0] fq[$];
    logic [7:0] cs;

    task automatic push_c(input logic [7:0] b);
        fq.push_back(b);
        cs = cs ^ b;
    endtask

    task automatic hdr(input logic [12:0] a, input logic [13:0] l);
        fq.push_back(8'hA5);
        cs = 8'd0;
        push_c(a[7:0]);
        push_c({3'b000, a[12:8]});
        push_c(l[7:0]);
        push_c({2'b00, l[13:8]});
    endtask

    task automatic tail;
`ifdef UART_MEM_LOADER_CSUM_EN
        fq.push_back(cs);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            vectors++; miscompares++;
            $display("FAIL send_byte: rx_ready stuck low, got %b want 1", rx_ready);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_q;
        while (fq.size() > 0) send_byte(fq.pop_front());
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        settle(2);
        vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_rx_ready got %b want 1", rx_ready); end
        vectors++; if (mem_clken !== 1'b1) begin miscompares++; $display("FAIL reset_clken got %b want 1", mem_clken); end
        vectors++; if ({mem_write, mem_chipselect, busy, done, error} !== 5'b0) begin
            miscompares++; $display("FAIL reset_ctrl got %b want 00000", {mem_write, mem_chipselect, busy, done, error}); end
        vectors++; if ({mem_address, mem_byteenable, mem_writedata} !== 49'd0) begin
            miscompares++; $display("FAIL reset_bus got %h want 0", {mem_address, mem_byteenable, mem_writedata}); end
        reset = 1'b0;
        settle(1);
    endtask

    task automatic test_two_words;
        snap;
        hdr(13'h010, 14'd2);
        push_c(8'h11); push_c(8'h22); push_c(8'h33); push_c(8'h44);
        push_c(8'h55); push_c(8'h66); push_c(8'h77); push_c(8'h88);
        tail;
        send_q;
        settle(4);
        vectors++; if (wa.size() - b_w !== 2) begin miscompares++; $display("FAIL tw_count got %0d want 2", wa.size() - b_w); end
        vectors++; if (wa[b_w] !== 13'h010 || wd[b_w] !== 32'h44332211) begin
            miscompares++; $display("FAIL tw_w0 got %h@%h want 44332211@010", wd[b_w], wa[b_w]); end
        vectors++; if (wa[b_w+1] !== 13'h011 || wd[b_w+1] !== 32'h88776655) begin
            miscompares++; $display("FAIL tw_w1 got %h@%h want 88776655@011", wd[b_w+1], wa[b_w+1]); end
        vectors++; if (n_done - b_d !== 1 || n_err - b_e !== 0) begin
            miscompares++; $display("FAIL tw_done got done=%0d err=%0d want 1/0", n_done - b_d, n_err - b_e); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL tw_busy got %b want 0", busy); end
    endtask

    task automatic test_junk;
        snap;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        settle(1);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL junk_busy got %b want 0", busy); end
        hdr(13'h123, 14'd1);
        push_c(8'hDE); push_c(8'hAD); push_c(8'hBE); push_c(8'hEF);
        tail;
        send_q;
        settle(4);
        vectors++; if (wa.size() - b_w !== 1) begin miscompares++; $display("FAIL junk_count got %0d want 1", wa.size() - b_w); end
        vectors++; if (wa[b_w] !== 13'h123 || wd[b_w] !== 32'hEFBEADDE) begin
            miscompares++; $display("FAIL junk_word got %h@%h want efbeadde@123", wd[b_w], wa[b_w]); end
        vectors++; if (n_done - b_d !== 1) begin miscompares++; $display("FAIL junk_done got %0d want 1", n_done - b_d); end
    endtask

    task automatic test_wrap;
        snap;
        hdr(13'h1FFF, 14'd2);
        for (int i = 1; i <= 8; i++) push_c(8'(i));
        tail;
        send_q;
        settle(4);
        vectors++; if (wa.size() - b_w !== 2) begin miscompares++; $display("FAIL wrap_count got %0d want 2", wa.size() - b_w); end
        vectors++; if (wa[b_w] !== 13'h1FFF || wd[b_w] !== 32'h04030201) begin
            miscompares++; $display("FAIL wrap_w0 got %h@%h want 04030201@1fff", wd[b_w], wa[b_w]); end
        vectors++; if (wa[b_w+1] !== 13'h0000 || wd[b_w+1] !== 32'h08070605) begin
            miscompares++; $display("FAIL wrap_w1 got %h@%h want 08070605@0000", wd[b_w+1], wa[b_w+1]); end
    endtask

    task automatic test_len_bounds;
        snap;
        hdr(13'h050, 14'd0);
        tail;
        send_q;
        settle(4);
        vectors++; if (wa.size() - b_w !== 0 || n_done - b_d !== 1) begin
            miscompares++; $display("FAIL len0 got writes=%0d done=%0d want 0/1", wa.size() - b_w, n_done - b_d); end
        snap;
        hdr(13'h000, 14'h2001);
        send_q;
        settle(4);
        vectors++; if (wa.size() - b_w !== 0 || n_err - b_e !== 1 || n_done - b_d !== 0) begin
            miscompares++; $display("FAIL len2001 got writes=%0d err=%0d done=%0d want 0/1/0",
                                    wa.size() - b_w, n_err - b_e, n_done - b_d); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL len2001_busy got %b want 0", busy); end
        // 0x2000 is the largest legal length: header accepted, frame stays open
        snap;
        hdr(13'h000, 14'h2000);
        send_q;
        settle(3);
        vectors++; if (n_err - b_e !== 0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL len2000 got err=%0d busy=%b want 0/1", n_err - b_e, busy); end
        pulse_reset;
    endtask

    task automatic test_timeout;
        snap;
        hdr(13'h020, 14'd1);
        push_c(8'hAA); push_c(8'hBB);
        send_q;
        settle(TO - 4);
        vectors++; if (n_err - b_e !== 0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL to_early got err=%0d busy=%b want 0/1", n_err - b_e, busy); end
        settle(8);
        vectors++; if (n_err - b_e !== 1 || wa.size() - b_w !== 0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL to_abort got err=%0d writes=%0d busy=%b want 1/0/0",
                                    n_err - b_e, wa.size() - b_w, busy); end
        snap;
        hdr(13'h021, 14'd1);
        push_c(8'h01); push_c(8'h02); push_c(8'h03); push_c(8'h04);
        tail;
        send_q;
        settle(4);
        vectors++; if (wa.size() - b_w !== 1 || wa[b_w] !== 13'h021 || wd[b_w] !== 32'h04030201 || n_done - b_d !== 1) begin
            miscompares++; $display("FAIL to_next got n=%0d %h@%h done=%0d want 1 04030201@021 1",
                                    wa.size() - b_w, wd[b_w], wa[b_w], n_done - b_d); end
    endtask

    task automatic test_csum;
`ifdef UART_MEM_LOADER_CSUM_EN
        snap;
        hdr(13'h030, 14'd1);
        push_c(8'h10); push_c(8'h20); push_c(8'h30); push_c(8'h40);
        tail;
        send_q;
        settle(4);
        vectors++; if (n_done - b_d !== 1 || n_err - b_e !== 0) begin
            miscompares++; $display("FAIL csum_ok got done=%0d err=%0d want 1/0", n_done - b_d, n_err - b_e); end
        snap;
        hdr(13'h031, 14'd1);
        push_c(8'h10); push_c(8'h20); push_c(8'h30); push_c(8'h40);
        fq.push_back(cs ^ 8'h01);
        send_q;
        settle(4);
        vectors++; if (n_done - b_d !== 0 || n_err - b_e !== 1 || wa.size() - b_w !== 1) begin
            miscompares++; $display("FAIL csum_bad got done=%0d err=%0d writes=%0d want 0/1/1",
                                    n_done - b_d, n_err - b_e, wa.size() - b_w); end
`endif
    endtask

    task automatic test_reset_mid;
        snap;
        hdr(13'h040, 14'd1);
        push_c(8'hC1); push_c(8'hC2);
        send_q;
        pulse_reset;
        settle(2);
        vectors++; if (busy !== 1'b0 || wa.size() - b_w !== 0) begin
            miscompares++; $display("FAIL rst_mid got busy=%b writes=%0d want 0/0", busy, wa.size() - b_w); end
        snap;
        hdr(13'h041, 14'd1);
        push_c(8'h0A); push_c(8'h0B); push_c(8'h0C); push_c(8'h0D);
        tail;
        send_q;
        settle(4);
        vectors++; if (wa.size() - b_w !== 1 || wa[b_w] !== 13'h041 || wd[b_w] !== 32'h0D0C0B0A) begin
            miscompares++; $display("FAIL rst_next got n=%0d %h@%h want 1 0d0c0b0a@041",
                                    wa.size() - b_w, wd[b_w], wa[b_w]); end
    endtask

    task automatic test_invariants;
        vectors++; if (rdy_bad !== 0) begin miscompares++; $display("FAIL rx_ready_vs_write got %0d bad cycles want 0", rdy_bad); end
        vectors++; if (both_bad !== 0) begin miscompares++; $display("FAIL done_and_error got %0d want 0", both_bad); end
        vectors++; if (be_bad !== 0) begin miscompares++; $display("FAIL write_strobes got %0d bad want 0", be_bad); end
    endtask

    initial begin
        test_reset;
        test_two_words;
        test_junk;
        test_wrap;
        test_len_bounds;
        test_timeout;
        test_csum;
        test_reset_mid;
        test_invariants;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
